// File: rtl/inversor_serial.sv
// inversor_serial: bit-serial two's-complement / ones'-complement / abs unit.
// Processes an N-bit operand LSB first, one bit per clock, using the
// copy-until-first-one / invert-after rule, so no N-bit adder is needed.
module inversor_serial #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   mode,
  input  logic [N-1:0] in,
  output logic [N-1:0] out,
  output logic         busy,
  output logic         done,
  output logic         ovf,
  output logic         zero
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Effective per-bit operations once abs has been resolved at start.
  localparam logic [1:0] M_PASS = 2'b00;
  localparam logic [1:0] M_NEG  = 2'b01;
  localparam logic [1:0] M_ABS  = 2'b10;
  localparam logic [1:0] M_ONES = 2'b11;

  localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);
  localparam logic [N-1:0]  MOST_NEG = {1'b1, {(N-1){1'b0}}};

  logic [1:0]    r_state;
  logic [N-1:0]  r_sh;
  logic [N-1:0]  r_res;
  logic [1:0]    r_mode;
  logic          r_s;
  logic [CW-1:0] r_cnt;
  logic          r_cand;
  logic [N-1:0]  r_out;
  logic          r_ovf;
  logic          r_zero;

  logic          w_b;
  logic          w_r;
  logic [N-1:0]  w_res_next;
  logic [1:0]    w_mode_eff;
  logic          w_accept;
  logic          w_cand;

  // Per-bit result, next result word and start-time decode.
  always_comb begin
    w_b = r_sh[0];
    w_r = w_b;
    case (r_mode)
      M_NEG:   w_r = r_s ? ~w_b : w_b;
      M_ONES:  w_r = ~w_b;
      default: w_r = w_b;
    endcase
    w_res_next = {w_r, r_res[N-1:1]};

    // abs collapses to negate or pass depending on the operand sign.
    w_mode_eff = mode;
    if (mode == M_ABS) begin
      w_mode_eff = in[N-1] ? M_NEG : M_PASS;
    end
    w_cand = ((mode == M_NEG) || (mode == M_ABS)) && (in == MOST_NEG);

    // A request is taken in IDLE and also on the edge that leaves DONE,
    // which gives back-to-back operation every N+1 cycles.
    w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  end

  // Control FSM, serial datapath and registered result/flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sh    <= '0;
      r_res   <= '0;
      r_mode  <= M_PASS;
      r_s     <= 1'b0;
      r_cnt   <= '0;
      r_cand  <= 1'b0;
      r_out   <= '0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            r_state <= S_RUN;
            r_sh    <= in;
            r_mode  <= w_mode_eff;
            r_s     <= 1'b0;
            r_cnt   <= '0;
            r_cand  <= w_cand;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_sh  <= {1'b0, r_sh[N-1:1]};
          r_res <= w_res_next;
          r_s   <= r_s | w_b;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_BIT) begin
            r_state <= S_DONE;
            r_out   <= w_res_next;
            r_ovf   <= r_cand;
            r_zero  <= (w_res_next == '0);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out  = r_out;
  assign ovf  = r_ovf;
  assign zero = r_zero;
  assign busy = (r_state == S_RUN) || (r_state == S_DONE);
  assign done = (r_state == S_DONE);

endmodule

// File: tb/tb_inversor_serial.sv
// Self-checking bench for inversor_serial at N=4 and N=8.
module tb_inversor_serial;

  logic       clk = 1'b0;
  logic       rst;
  logic       start4, start8;
  logic [1:0] mode4, mode8;
  logic [3:0] in4, out4;
  logic [7:0] in8, out8;
  logic       busy4, done4, ovf4, zero4;
  logic       busy8, done8, ovf8, zero8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  inversor_serial #(.N(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .mode(mode4), .in(in4),
    .out(out4), .busy(busy4), .done(done4), .ovf(ovf4), .zero(zero4)
  );

  inversor_serial #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .mode(mode8), .in(in8),
    .out(out8), .busy(busy8), .done(done8), .ovf(ovf8), .zero(zero8)
  );

  typedef struct {
    logic [1:0] m;
    logic [3:0] v;
    logic [3:0] eo;
    logic       eov;
    logic       ez;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: plain modulo-2^w arithmetic on the operand value.
  task automatic model(input logic [1:0] m, input int v, input int w,
                       output int r, output int o, output int z);
    int md;
    md = 1 << w;
    case (m)
      2'b00: r = v;
      2'b01: r = (md - v) % md;
      2'b10: r = (v >= md / 2) ? (md - v) % md : v;
      default: r = md - 1 - v;
    endcase
    o = ((m == 2'b01) || (m == 2'b10)) && (v == md / 2) ? 1 : 0;
    z = (r == 0) ? 1 : 0;
  endtask

  // One N=4 operation; called #1 after a rising edge. Optionally pulses
  // start again during RUN with different operands, which must be ignored.
  task automatic op4(input logic [1:0] m, input logic [3:0] v, input logic [3:0] eo,
                     input logic eov, input logic ez, input bit noise);
    int busy_n, lat;
    logic [3:0] hold;
    hold = out4;
    start4 = 1'b1; mode4 = m; in4 = v;
    @(posedge clk); #1;
    start4 = 1'b0; mode4 = 2'($urandom); in4 = 4'($urandom);
    busy_n = busy4 ? 1 : 0;
    lat = 0;
    for (int k = 1; k <= 12 && lat == 0; k++) begin
      if (noise && k == 1) begin start4 = 1'b1; in4 = ~v; mode4 = ~m; end
      if (noise && k == 2) start4 = 1'b0;
      @(posedge clk); #1;
      if (busy4) busy_n++;
      if (done4) lat = k;
      else chk("out4_hold", int'(out4), int'(hold));
    end
    chk("done4_latency", lat, 4);
    chk("busy4_cycles", busy_n, 5);
    chk("out4", int'(out4), int'(eo));
    chk("ovf4", int'(ovf4), int'(eov));
    chk("zero4", int'(zero4), int'(ez));
    $display("N4 mode=%b in=%b out=%b ovf=%b zero=%b lat=%0d", m, v, out4, ovf4, zero4, lat);
  endtask

  task automatic idle_check4();
    @(posedge clk); #1;
    chk("done4_single", int'(done4), 0);
    chk("busy4_fall", int'(busy4), 0);
  endtask

  task automatic op8(input logic [1:0] m, input logic [7:0] v);
    int r, o, z, busy_n, lat;
    model(m, int'(v), 8, r, o, z);
    start8 = 1'b1; mode8 = m; in8 = v;
    @(posedge clk); #1;
    start8 = 1'b0; mode8 = 2'($urandom); in8 = 8'($urandom);
    busy_n = busy8 ? 1 : 0;
    lat = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(posedge clk); #1;
      if (busy8) busy_n++;
      if (done8) lat = k;
    end
    chk("done8_latency", lat, 8);
    chk("busy8_cycles", busy_n, 9);
    chk("out8", int'(out8), r);
    chk("ovf8", int'(ovf8), o);
    chk("zero8", int'(zero8), z);
    $display("N8 mode=%b in=%h out=%h ovf=%b zero=%b lat=%0d", m, v, out8, ovf8, zero8, lat);
  endtask

  initial begin
    int r, o, z, seen;
    logic [1:0] rm;
    logic [3:0] rv;

    vecs[0] = '{2'b01, 4'b0011, 4'b1101, 1'b0, 1'b0};
    vecs[1] = '{2'b01, 4'b1000, 4'b1000, 1'b1, 1'b0};
    vecs[2] = '{2'b01, 4'b0000, 4'b0000, 1'b0, 1'b1};
    vecs[3] = '{2'b10, 4'b1000, 4'b1000, 1'b1, 1'b0};
    vecs[4] = '{2'b10, 4'b1010, 4'b0110, 1'b0, 1'b0};
    vecs[5] = '{2'b10, 4'b0101, 4'b0101, 1'b0, 1'b0};
    vecs[6] = '{2'b11, 4'b0000, 4'b1111, 1'b0, 1'b0};
    vecs[7] = '{2'b00, 4'b1001, 4'b1001, 1'b0, 1'b0};
    vecs[8] = '{2'b11, 4'b1111, 4'b0000, 1'b0, 1'b1};
    vecs[9] = '{2'b01, 4'b0111, 4'b1001, 1'b0, 1'b0};

    rst = 1'b1;
    start4 = 1'b0; mode4 = 2'b00; in4 = 4'b0;
    start8 = 1'b0; mode8 = 2'b00; in8 = 8'b0;
    #1;
    chk("reset_out4", int'(out4), 0);
    chk("reset_busy4", int'(busy4), 0);
    chk("reset_done4", int'(done4), 0);
    chk("reset_flags4", int'({ovf4, zero4}), 0);
    chk("reset_out8", int'(out8), 0);
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Directed vectors at N=4.
    for (int i = 0; i < 10; i++) begin
      op4(vecs[i].m, vecs[i].v, vecs[i].eo, vecs[i].eov, vecs[i].ez, 1'b0);
      idle_check4();
    end

    // start during RUN is ignored.
    op4(2'b01, 4'b0011, 4'b1101, 1'b0, 1'b0, 1'b1);
    idle_check4();

    // Back-to-back: second start sampled at EN+1; out holds meanwhile.
    op4(2'b01, 4'b0110, 4'b1010, 1'b0, 1'b0, 1'b0);
    op4(2'b11, 4'b0101, 4'b1010, 1'b0, 1'b0, 1'b0);
    idle_check4();

    // Reset two cycles into RUN.
    op4(2'b01, 4'b0011, 4'b1101, 1'b0, 1'b0, 1'b0);
    idle_check4();
    start4 = 1'b1; mode4 = 2'b01; in4 = 4'b0101;
    @(posedge clk); #1; start4 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst_out4", int'(out4), 0);
    chk("midrst_ovf4", int'(ovf4), 0);
    chk("midrst_zero4", int'(zero4), 0);
    chk("midrst_busy4", int'(busy4), 0);
    chk("midrst_done4", int'(done4), 0);
    @(posedge clk); @(posedge clk);
    @(negedge clk); rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (done4 || busy4) seen++;
    end
    chk("midrst_no_done", seen, 0);
    op4(2'b01, 4'b0101, 4'b1011, 1'b0, 1'b0, 1'b0);
    idle_check4();

    // Random N=4 sweep against the arithmetic model.
    for (int i = 0; i < 16; i++) begin
      rm = 2'($urandom_range(0, 3));
      rv = 4'($urandom);
      model(rm, int'(rv), 4, r, o, z);
      op4(rm, rv, 4'(r), o[0], z[0], 1'b0);
    end
    idle_check4();

    // N=8 directed and random.
    op8(2'b01, 8'h01);
    op8(2'b10, 8'h80);
    op8(2'b01, 8'h00);
    for (int i = 0; i < 40; i++) begin
      op8(2'($urandom_range(0, 3)), 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
